// File: rtl/seven_segment_ctrl_pkg.sv
// Shared definitions for the seven-segment display peripheral.
// Holds the register map, the CTRL bit layout, the key debounce state
// encoding and a byte-enable merge helper used by the DATA register.
package seven_segment_ctrl_pkg;

  // Register select (i_addr)
  localparam logic ADDR_DATA = 1'b0;
  localparam logic ADDR_CTRL = 1'b1;

  // CTRL register bit positions
  localparam int CTRL_MODE_BIT = 0;
  localparam int CTRL_AUTO_BIT = 1;

  // Key debounce FSM states
  typedef enum logic [1:0] {
    UP      = 2'd0,
    WAIT_DN = 2'd1,
    DOWN    = 2'd2,
    WAIT_UP = 2'd3
  } db_state_t;

  // Replace only the bytes whose enable bit is set.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int n = 0; n < 4; n++) begin
      if (be[n]) res[8*n +: 8] = new_val[8*n +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Push-button conditioner: 2-flop synchronizer followed by a four-state
// debounce FSM. A press is accepted only after DEBOUNCE_CYCLES consecutive
// low samples; release is debounced the same way but produces no event.
// Ports:
//   i_clk    system clock, rising edge
//   i_rst    asynchronous, active-high reset
//   i_key_n  raw active-low button, asynchronous to i_clk
//   o_press  one-cycle pulse on an accepted press
//   o_level  debounced level, 1 = released, 0 = held
module key_debounce
  import seven_segment_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_key_n,
  output logic o_press,
  output logic o_level
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  db_state_t        r_state;
  db_state_t        w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_press;
  logic             w_press_nxt;

  // Synchronizer idles high so a reset never looks like a pressed key.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_key_n;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= UP;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_press <= w_press_nxt;
    end
  end

  // The counter only runs in the two WAIT states and is zeroed on every
  // transition, so it stops at CNT_LAST and can never wrap.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_press_nxt = 1'b0;
    unique case (r_state)
      UP: begin
        if (!r_sync2) begin
          w_state_nxt = WAIT_DN;
          w_cnt_nxt   = '0;
        end
      end
      WAIT_DN: begin
        if (r_sync2) begin
          w_state_nxt = UP;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = DOWN;
          w_cnt_nxt   = '0;
          w_press_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      DOWN: begin
        if (r_sync2) begin
          w_state_nxt = WAIT_UP;
          w_cnt_nxt   = '0;
        end
      end
      WAIT_UP: begin
        if (!r_sync2) begin
          w_state_nxt = DOWN;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = UP;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = UP;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign o_press = r_press;
  assign o_level = (r_state == UP) || (r_state == WAIT_DN);

endmodule

// File: rtl/seven_segment_ctrl.sv
// Bus-programmable front end for a 32-bit seven-segment decoder.
// DATA holds the 32-bit value to show; CTRL selects which 16-bit half is
// displayed (mode) and enables automatic half-swapping (auto_en). The half
// can also be swapped by a debounced push button.
// Ports:
//   i_clk, i_rst       clock (rising edge) and async active-high reset
//   i_we, i_re         single-cycle write / read strobes
//   i_addr             0 = DATA, 1 = CTRL
//   i_wdata, i_be      write data and DATA byte enables
//   o_rdata, o_rvalid  read data, valid one cycle after i_re
//   i_key_n            raw active-low button
//   o_data, o_mode     drive the decoder's i_data / i_mode directly
module seven_segment_ctrl
  import seven_segment_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int AUTO_PERIOD     = 50000000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_we,
  input  logic        i_re,
  input  logic        i_addr,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_be,
  output logic [31:0] o_rdata,
  output logic        o_rvalid,
  input  logic        i_key_n,
  output logic [31:0] o_data,
  output logic        o_mode
);

  localparam int TMR_W = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(AUTO_PERIOD - 1);

  logic [31:0]      r_data;
  logic             r_mode;
  logic             r_auto_en;
  logic [TMR_W-1:0] r_timer;
  logic [31:0]      r_rdata;
  logic             r_rvalid;

  logic             w_press;
  logic             w_key_level_unused;
  logic             w_data_wr;
  logic             w_ctrl_wr;
  logic             w_tmr_expire;
  logic [31:0]      w_ctrl_word;
  logic [31:0]      w_rd_sel;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_key_n(i_key_n),
    .o_press(w_press),
    .o_level(w_key_level_unused)
  );

  assign w_data_wr    = i_we && (i_addr == ADDR_DATA);
  assign w_ctrl_wr    = i_we && (i_addr == ADDR_CTRL);
  assign w_tmr_expire = r_auto_en && (r_timer == TMR_LAST);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_data <= '0;
    end else if (w_data_wr) begin
      r_data <= merge_bytes(r_data, i_wdata, i_be);
    end
  end

  // Mode sources are mutually exclusive per cycle: a CTRL write beats a
  // button press, which beats timer expiry. Any of the three restarts the
  // timer, as does auto_en being off.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mode    <= 1'b0;
      r_auto_en <= 1'b0;
      r_timer   <= '0;
    end else begin
      if (w_ctrl_wr) begin
        r_mode    <= i_wdata[CTRL_MODE_BIT];
        r_auto_en <= i_wdata[CTRL_AUTO_BIT];
      end else if (w_press || w_tmr_expire) begin
        r_mode <= ~r_mode;
      end

      if (w_ctrl_wr || w_press || w_tmr_expire || !r_auto_en) begin
        r_timer <= '0;
      end else begin
        r_timer <= r_timer + TMR_W'(1);
      end
    end
  end

  always_comb begin
    w_ctrl_word                = '0;
    w_ctrl_word[CTRL_MODE_BIT] = r_mode;
    w_ctrl_word[CTRL_AUTO_BIT] = r_auto_en;
  end

  assign w_rd_sel = (i_addr == ADDR_CTRL) ? w_ctrl_word : r_data;

  // Read data is captured from the current register values, so a write in
  // the same cycle is not yet visible.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= i_re;
      r_rdata  <= i_re ? w_rd_sel : '0;
    end
  end

  assign o_rdata  = r_rdata;
  assign o_rvalid = r_rvalid;
  assign o_data   = r_data;
  assign o_mode   = r_mode;

endmodule

// File: tb/tb_seven_segment_ctrl.sv
module tb_seven_segment_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic        re;
  logic        addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [31:0] rdata;
  logic        rvalid;
  logic        key_n;
  logic [31:0] data;
  logic        mode;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seven_segment_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .AUTO_PERIOD    (8)
  ) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_we    (we),
    .i_re    (re),
    .i_addr  (addr),
    .i_wdata (wdata),
    .i_be    (be),
    .o_rdata (rdata),
    .o_rvalid(rvalid),
    .i_key_n (key_n),
    .o_data  (data),
    .o_mode  (mode)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic a, input logic [31:0] d, input logic [3:0] b);
    addr  = a;
    wdata = d;
    be    = b;
    we    = 1'b1;
    tick(1);
    we = 1'b0;
  endtask

  task automatic rd(input logic a, input logic [31:0] exp, input string tag);
    addr = a;
    re   = 1'b1;
    tick(1);
    re = 1'b0;
    chk({tag, "_rvalid"}, {31'd0, rvalid}, 32'd1);
    chk(tag, rdata, exp);
  endtask

  initial begin
    rst   = 1'b1;
    we    = 1'b0;
    re    = 1'b0;
    addr  = 1'b0;
    wdata = '0;
    be    = '0;
    key_n = 1'b1;
    #1;
    chk("rst_data",   data,               32'd0);
    chk("rst_mode",   {31'd0, mode},      32'd0);
    chk("rst_rvalid", {31'd0, rvalid},    32'd0);
    chk("rst_rdata",  rdata,              32'd0);
    tick(2);
    rst = 1'b0;

    // DATA full write, then byte-1-only write
    wr(1'b0, 32'hDEAD_BEEF, 4'hF);
    chk("data_full", data, 32'hDEAD_BEEF);
    wr(1'b0, 32'h0000_1200, 4'b0010);
    chk("data_byte1", data, 32'hDEAD_12EF);
    addr = 1'b0;
    re   = 1'b1;
    chk("rvalid_not_early", {31'd0, rvalid}, 32'd0);
    tick(1);
    re = 1'b0;
    chk("rd_data_rvalid", {31'd0, rvalid}, 32'd1);
    chk("rd_data", rdata, 32'hDEAD_12EF);
    tick(1);
    chk("idle_rvalid", {31'd0, rvalid}, 32'd0);
    chk("idle_rdata",  rdata,           32'd0);

    // 3-cycle key glitch: rejected
    key_n = 1'b0;
    tick(3);
    key_n = 1'b1;
    tick(10);
    chk("glitch_mode", {31'd0, mode}, 32'd0);

    // 10-cycle hold: toggles once, 8 edges after the key drop
    key_n = 1'b0;
    tick(7);
    chk("press_early", {31'd0, mode}, 32'd0);
    tick(1);
    chk("press_toggle", {31'd0, mode}, 32'd1);
    tick(2);
    key_n = 1'b1;
    tick(12);
    chk("release_no_toggle", {31'd0, mode}, 32'd1);

    // Auto swap every 8 cycles
    wr(1'b1, 32'h0000_0002, 4'hF);
    chk("auto_start_mode", {31'd0, mode}, 32'd0);
    rd(1'b1, 32'd2, "rd_ctrl_2");
    chk("rd_ctrl_2_mode", {31'd0, mode}, 32'd0);
    tick(6);
    chk("auto_pre1", {31'd0, mode}, 32'd0);
    tick(1);
    chk("auto_t1", {31'd0, mode}, 32'd1);
    rd(1'b1, 32'd3, "rd_ctrl_3");
    chk("rd_ctrl_3_mode", {31'd0, mode}, 32'd1);
    tick(6);
    chk("auto_pre2", {31'd0, mode}, 32'd1);
    tick(1);
    chk("auto_t2", {31'd0, mode}, 32'd0);
    wr(1'b1, 32'h0000_0000, 4'hF);
    chk("auto_off_mode", {31'd0, mode}, 32'd0);

    // Press pulse and CTRL write (mode=0, auto_en=1) in the same cycle
    key_n = 1'b0;
    tick(7);
    wr(1'b1, 32'h0000_0002, 4'hF);
    chk("coincide_mode", {31'd0, mode}, 32'd0);
    tick(7);
    chk("coincide_timer_pre", {31'd0, mode}, 32'd0);
    tick(1);
    chk("coincide_timer_wrap", {31'd0, mode}, 32'd1);
    wr(1'b1, 32'h0000_0000, 4'hF);
    key_n = 1'b1;
    tick(12);
    chk("coincide_after", {31'd0, mode}, 32'd0);

    // Same-cycle write and read of DATA
    addr  = 1'b0;
    wdata = 32'h1234_5678;
    be    = 4'hF;
    we    = 1'b1;
    re    = 1'b1;
    tick(1);
    we = 1'b0;
    re = 1'b0;
    chk("rw_old_rvalid", {31'd0, rvalid}, 32'd1);
    chk("rw_old_rdata", rdata, 32'hDEAD_12EF);
    chk("rw_new_data", data, 32'h1234_5678);
    rd(1'b0, 32'h1234_5678, "rw_new_rdata");

    // Reset in WAIT_DN with auto_en=1 and a read in flight
    wr(1'b1, 32'h0000_0003, 4'hF);
    chk("pre_rst_mode", {31'd0, mode}, 32'd1);
    key_n = 1'b0;
    tick(3);
    addr = 1'b0;
    re   = 1'b1;
    tick(1);
    re = 1'b0;
    chk("pre_rst_rvalid", {31'd0, rvalid}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_data",   data,            32'd0);
    chk("mid_rst_mode",   {31'd0, mode},   32'd0);
    chk("mid_rst_rvalid", {31'd0, rvalid}, 32'd0);
    chk("mid_rst_rdata",  rdata,           32'd0);
    key_n = 1'b1;
    tick(2);
    rst = 1'b0;

    key_n = 1'b0;
    tick(3);
    key_n = 1'b1;
    tick(10);
    chk("post_rst_glitch", {31'd0, mode}, 32'd0);
    chk("post_rst_data", data, 32'd0);

    // First press after reset needs the full debounce period
    key_n = 1'b0;
    tick(7);
    chk("post_rst_press_early", {31'd0, mode}, 32'd0);
    tick(1);
    chk("post_rst_press", {31'd0, mode}, 32'd1);
    key_n = 1'b1;
    tick(12);
    rd(1'b1, 32'd1, "post_rst_ctrl");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seven_segment_ctrl.md
SEVEN_SEGMENT_CTRL -- requirements
Module: seven_segment_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, SHALL set the number of consecutive stable cycles (20 ms at 50 MHz) needed to accept a key level.
REQ-002 Parameter AUTO_PERIOD, default 50000000, SHALL set the cycles between automatic half-swaps (1 s at 50 MHz).
REQ-003 One clock and one reset; reset is asynchronous and active-high. Ports SHALL be, one per line (name  direction  width  meaning):
- i_clk  input  1  system clock, rising edge
- i_rst  input  1  asynchronous, active-high reset
- i_we  input  1  bus write strobe, single cycle
- i_re  input  1  bus read strobe, single cycle
- i_addr  input  1  register select: 0 = DATA, 1 = CTRL
- i_wdata  input  32  write data
- i_be  input  4  byte enables for DATA writes
- o_rdata  output  32  read data
- o_rvalid  output  1  read data valid
- i_key_n  input  1  raw active-low push button, asynchronous to i_clk
- o_data  output  32  value shown on the display
- o_mode  output  1  half select: 0 = bits 15:0, 1 = bits 31:16
REQ-004 o_data and o_mode SHALL drive the 32-bit seven-segment decoder's i_data and i_mode directly, with no further logic between them.

Function
REQ-005 DATA register: on i_we with i_addr=0, byte n SHALL update from i_wdata[8n+7:8n] only where i_be[n]=1; o_data SHALL reflect the new value on the next cycle.
REQ-006 CTRL register: bit0 = mode and bit1 = auto_en; bits 31:2 SHALL be ignored on write and read as 0.
REQ-007 A CTRL write SHALL load mode and auto_en on the next edge and clear the auto timer.
REQ-008 Read: i_re SHALL produce o_rvalid=1 exactly one cycle later, with o_rdata holding the selected register; otherwise o_rvalid=0 and o_rdata=0.
REQ-009 Simultaneous i_we and i_re to the same address SHALL return the pre-write value.
REQ-010 i_key_n SHALL pass through a 2-flop synchronizer before any other use.
REQ-011 Debounce FSM states SHALL be UP, WAIT_DN, DOWN and WAIT_UP.
- UP to WAIT_DN on sync key = 0.
- WAIT_DN to DOWN after DEBOUNCE_CYCLES consecutive low cycles; any high cycle returns it to UP.
- DOWN to WAIT_UP on sync key = 1.
- WAIT_UP to UP after DEBOUNCE_CYCLES consecutive high cycles; any low cycle returns it to DOWN.
- The counter SHALL clear on every state change.
REQ-012 The WAIT_DN to DOWN transition SHALL issue a one-cycle press pulse that toggles mode on the next edge and clears the auto timer.
REQ-013 Holding the key SHALL produce exactly one toggle; release generates no event.
REQ-014 When auto_en=1, the timer SHALL count 0 to AUTO_PERIOD-1, then toggle mode and wrap to 0. When auto_en=0, the timer SHALL stay at 0.
REQ-015 Mode update priority when events coincide in the same cycle: CTRL write, then press pulse, then auto-timer expiry. Only one update SHALL apply per cycle.
REQ-016 Counter widths SHALL be $clog2 of the respective parameter, and counters SHALL never overflow past the terminal count.

Reset
REQ-017 Asserting i_rst at any time, including mid-debounce or mid-read, SHALL immediately force the following:
- DATA = 0, mode = 0, auto_en = 0
- timer = 0, debounce counter = 0
- FSM = UP, synchronizer flops = 1
- o_rvalid = 0, o_rdata = 0
REQ-018 After reset deasserts, the first accepted press SHALL still require the full DEBOUNCE_CYCLES low period.

Structure
REQ-019 The register addresses, CTRL bit positions and the debounce state encoding SHALL live in the shared display/peripheral package.
REQ-020 The synchronizer and debounce FSM SHALL be a sub-module, key_debounce, with outputs press pulse and stable level; the register file and timer stay in the top module.

Verification
REQ-021 The bench SHALL use DEBOUNCE_CYCLES=4 and AUTO_PERIOD=8 and cover these directed scenarios:
- Write DATA=0xDEADBEEF with i_be=4'hF, then i_be=4'b0010 with i_wdata=0x00001200 -> o_data=0xDEAD12EF; a read returns the same value with o_rvalid one cycle after i_re.
- Hold i_key_n low for 3 cycles, then release -> mode unchanged. Hold it low for 10 cycles -> mode toggles exactly once, 4 cycles after sync.
- Write CTRL=0x2 -> o_mode toggles every 8 cycles (0 then 1 then 0). A CTRL read returns 0x2 or 0x3 matching o_mode.
- Press pulse and CTRL write of mode=0 in the same cycle -> o_mode=0 and the timer restarts from 0.
- Assert i_rst during WAIT_DN with auto_en=1 -> all outputs 0 immediately. After release, a 3-cycle low glitch causes no toggle.
- Simultaneous i_we and i_re to DATA -> o_rdata shows the old value, and the next read shows the new value.
